// File: rtl/pu_repetition_weight_packer.sv
// Packs L-bit repetition counts LSB-first into W-bit SRAM words, straddling word boundaries.
// Latency: a word is presented on SRAM_out the cycle after it fills; a count is taken per cycle when ready.
// Backpressure: count_ready drops while a word waits for word_done; enable=0 freezes all state.

`ifndef WEIGHT_SRAM_LEN
`define WEIGHT_SRAM_LEN 32
`endif
`ifndef MAX_WEIGHT_NUM_LEN
`define MAX_WEIGHT_NUM_LEN 16
`endif

module pu_repetition_weight_packer #(
  parameter int WEIGHT_SRAM_LEN    = `WEIGHT_SRAM_LEN,
  parameter int MAX_WEIGHT_NUM_LEN = `MAX_WEIGHT_NUM_LEN
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic                                  enable,
  input  logic                                  finish,
  input  logic [$clog2(MAX_WEIGHT_NUM_LEN)-1:0] weight_num_len,
  input  logic [MAX_WEIGHT_NUM_LEN-1:0]         count_in,
  input  logic                                  count_valid,
  output logic                                  count_ready,
  output logic [WEIGHT_SRAM_LEN-1:0]            SRAM_out,
  output logic                                  word_write,
  input  logic                                  word_done,
  output logic [31:0]                           word_counter,
  output logic                                  busy,
  output logic                                  done
);

  localparam int W    = WEIGHT_SRAM_LEN;
  localparam int M    = MAX_WEIGHT_NUM_LEN;
  localparam int LW   = $clog2(M);
  // valid_num spans 0..W-1+M, so $clog2(W+M) bits are enough.
  localparam int VN_W = $clog2(W + M);
  localparam logic [VN_W-1:0] W_VN = VN_W'(W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_WRITE,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [2*W-1:0]    staging_q, staging_d;
  logic [VN_W-1:0]   valid_num_q, valid_num_d;
  logic [31:0]       word_counter_q, word_counter_d;
  logic [LW-1:0]     len_q, len_d;
  logic              fin_pend_q, fin_pend_d;

  logic [M-1:0]      field_mask;
  logic [2*W-1:0]    field_shifted;
  logic [VN_W-1:0]   len_ext;
  logic [VN_W-1:0]   vn_acc;
  logic [2*W-1:0]    stg_acc;

  // Masked count field aligned to the first free bit of the staging register.
  always_comb begin
    field_mask    = ({{(M-1){1'b0}}, 1'b1} << len_q) - {{(M-1){1'b0}}, 1'b1};
    field_shifted = {{(2*W-M){1'b0}}, count_in & field_mask} << valid_num_q;
    len_ext       = {{(VN_W-LW){1'b0}}, len_q};
  end

  // Next-state and output decode; enable=0 leaves every _d equal to its _q.
  always_comb begin
    state_d        = state_q;
    staging_d      = staging_q;
    valid_num_d    = valid_num_q;
    word_counter_d = word_counter_q;
    len_d          = len_q;
    fin_pend_d     = fin_pend_q;
    vn_acc         = valid_num_q;
    stg_acc        = staging_q;
    count_ready    = 1'b0;
    word_write     = 1'b0;
    SRAM_out       = '0;
    busy           = (state_q != S_IDLE);
    done           = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && enable) begin
          state_d     = S_ACCEPT;
          len_d       = weight_num_len;
          staging_d   = '0;
          valid_num_d = '0;
          fin_pend_d  = 1'b0;
        end
      end

      S_ACCEPT: begin
        count_ready = enable && (valid_num_q < W_VN);
        if (enable) begin
          if (count_valid && count_ready) begin
            stg_acc = staging_q | field_shifted;
            vn_acc  = valid_num_q + len_ext;
          end
          staging_d   = stg_acc;
          valid_num_d = vn_acc;
          if (vn_acc >= W_VN) begin
            // A finish arriving with a full word is held until the word drains.
            state_d    = S_WRITE;
            fin_pend_d = fin_pend_q | finish;
          end else if (finish || fin_pend_q) begin
            state_d    = (vn_acc != '0) ? S_FLUSH : S_DONE;
            fin_pend_d = 1'b0;
          end
        end
      end

      S_WRITE: begin
        word_write = 1'b1;
        SRAM_out   = staging_q[W-1:0];
        if (enable) begin
          if (finish) begin
            fin_pend_d = 1'b1;
          end
          if (word_done) begin
            staging_d      = staging_q >> W;
            valid_num_d    = valid_num_q - W_VN;
            word_counter_d = word_counter_q + 32'd1;
            state_d        = S_ACCEPT;
          end
        end
      end

      S_FLUSH: begin
        // Bits above valid_num are always zero, so the partial word is already padded.
        word_write = 1'b1;
        SRAM_out   = staging_q[W-1:0];
        if (enable && word_done) begin
          word_counter_d = word_counter_q + 32'd1;
          valid_num_d    = '0;
          staging_d      = '0;
          state_d        = S_DONE;
        end
      end

      S_DONE: begin
        done = 1'b1;
        if (enable) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= S_IDLE;
      staging_q      <= '0;
      valid_num_q    <= '0;
      word_counter_q <= '0;
      len_q          <= '0;
      fin_pend_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      staging_q      <= staging_d;
      valid_num_q    <= valid_num_d;
      word_counter_q <= word_counter_d;
      len_q          <= len_d;
      fin_pend_q     <= fin_pend_d;
    end
  end

  assign word_counter = word_counter_q;

endmodule

// File: tb/tb_pu_repetition_weight_packer.sv
// Cycle-table bench for the repetition weight packer (W=32, M=16).
// Each row drives inputs on the falling edge and checks all outputs 1ns later.
// Expected values are hand-computed per row.

module tb_pu_repetition_weight_packer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        enable;
  logic        finish;
  logic [3:0]  weight_num_len;
  logic [15:0] count_in;
  logic        count_valid;
  logic        count_ready;
  logic [31:0] SRAM_out;
  logic        word_write;
  logic        word_done;
  logic [31:0] word_counter;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  pu_repetition_weight_packer #(
    .WEIGHT_SRAM_LEN   (32),
    .MAX_WEIGHT_NUM_LEN(16)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .enable        (enable),
    .finish        (finish),
    .weight_num_len(weight_num_len),
    .count_in      (count_in),
    .count_valid   (count_valid),
    .count_ready   (count_ready),
    .SRAM_out      (SRAM_out),
    .word_write    (word_write),
    .word_done     (word_done),
    .word_counter  (word_counter),
    .busy          (busy),
    .done          (done)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        rst;
    logic        st;
    logic        en;
    logic        fin;
    logic        cv;
    logic [15:0] cin;
    logic        wd;
    logic [3:0]  len;
    logic        e_rdy;
    logic        e_wr;
    logic [31:0] e_sram;
    logic [31:0] e_wc;
    logic        e_busy;
    logic        e_done;
  } row_t;

  function automatic row_t mk(input logic rst, input logic st, input logic en,
                              input logic fin, input logic cv, input logic [15:0] cin,
                              input logic wd, input logic [3:0] len,
                              input logic e_rdy, input logic e_wr, input logic [31:0] e_sram,
                              input logic [31:0] e_wc, input logic e_busy, input logic e_done);
    row_t r;
    r.rst = rst; r.st = st; r.en = en; r.fin = fin; r.cv = cv; r.cin = cin;
    r.wd = wd; r.len = len; r.e_rdy = e_rdy; r.e_wr = e_wr; r.e_sram = e_sram;
    r.e_wc = e_wc; r.e_busy = e_busy; r.e_done = e_done;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic run_row(input row_t r, input string tag);
    @(negedge clock);
    reset          = r.rst;
    start          = r.st;
    enable         = r.en;
    finish         = r.fin;
    count_valid    = r.cv;
    count_in       = r.cin;
    word_done      = r.wd;
    weight_num_len = r.len;
    #1;
    chk({tag, ".count_ready"},  {31'd0, count_ready}, {31'd0, r.e_rdy});
    chk({tag, ".word_write"},   {31'd0, word_write},  {31'd0, r.e_wr});
    chk({tag, ".SRAM_out"},     SRAM_out,             r.e_sram);
    chk({tag, ".word_counter"}, word_counter,         r.e_wc);
    chk({tag, ".busy"},         {31'd0, busy},        {31'd0, r.e_busy});
    chk({tag, ".done"},         {31'd0, done},        {31'd0, r.e_done});
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; start = 1'b0; enable = 1'b1; finish = 1'b0;
    count_valid = 1'b0; count_in = '0; word_done = 1'b0; weight_num_len = '0;
    repeat (2) @(posedge clock);
  endtask

  row_t tbl_a[25];

  initial begin
    // L=8 word, stall on enable, held-off ack, empty finish, then L=4 masking with flush.
    tbl_a[0]  = mk(0,0,1,0,0,16'h0000,0,4'd8, 0,0,32'h0,0,0,0);
    tbl_a[1]  = mk(0,1,1,0,0,16'h0000,0,4'd8, 0,0,32'h0,0,0,0);
    tbl_a[2]  = mk(0,0,1,0,1,16'h0011,0,4'd8, 1,0,32'h0,0,1,0);
    tbl_a[3]  = mk(0,0,1,0,1,16'h0022,0,4'd8, 1,0,32'h0,0,1,0);
    tbl_a[4]  = mk(0,0,0,0,1,16'h0033,0,4'd8, 0,0,32'h0,0,1,0);
    tbl_a[5]  = mk(0,0,0,0,1,16'h0033,0,4'd8, 0,0,32'h0,0,1,0);
    tbl_a[6]  = mk(0,0,0,0,1,16'h0033,0,4'd8, 0,0,32'h0,0,1,0);
    tbl_a[7]  = mk(0,0,1,0,1,16'h0033,0,4'd8, 1,0,32'h0,0,1,0);
    tbl_a[8]  = mk(0,0,1,0,1,16'h0044,0,4'd8, 1,0,32'h0,0,1,0);
    tbl_a[9]  = mk(0,0,1,0,1,16'h0055,0,4'd8, 0,1,32'h44332211,0,1,0);
    tbl_a[10] = mk(0,0,1,0,1,16'h0055,0,4'd8, 0,1,32'h44332211,0,1,0);
    tbl_a[11] = mk(0,0,1,0,1,16'h0055,0,4'd8, 0,1,32'h44332211,0,1,0);
    tbl_a[12] = mk(0,0,1,0,1,16'h0055,0,4'd8, 0,1,32'h44332211,0,1,0);
    tbl_a[13] = mk(0,0,1,0,1,16'h0055,0,4'd8, 0,1,32'h44332211,0,1,0);
    tbl_a[14] = mk(0,0,0,0,0,16'h0000,1,4'd8, 0,1,32'h44332211,0,1,0);
    tbl_a[15] = mk(0,0,1,0,0,16'h0000,1,4'd8, 0,1,32'h44332211,0,1,0);
    tbl_a[16] = mk(0,0,1,1,0,16'h0000,0,4'd8, 1,0,32'h0,1,1,0);
    tbl_a[17] = mk(0,0,1,0,0,16'h0000,0,4'd8, 0,0,32'h0,1,1,1);
    tbl_a[18] = mk(0,1,1,0,0,16'h0000,0,4'd4, 0,0,32'h0,1,0,0);
    tbl_a[19] = mk(0,0,1,1,1,16'hFFF5,0,4'd4, 1,0,32'h0,1,1,0);
    tbl_a[20] = mk(0,0,1,0,0,16'h0000,0,4'd4, 0,1,32'h00000005,1,1,0);
    tbl_a[21] = mk(0,0,1,0,0,16'h0000,1,4'd4, 0,1,32'h00000005,1,1,0);
    tbl_a[22] = mk(0,0,1,0,0,16'h0000,0,4'd4, 0,0,32'h0,2,1,1);
    tbl_a[23] = mk(0,0,1,0,0,16'h0000,1,4'd4, 0,0,32'h0,2,0,0);
    tbl_a[24] = mk(0,0,1,0,0,16'h0000,0,4'd4, 0,0,32'h0,2,0,0);

    do_reset();
    for (int i = 0; i < 25; i++) begin
      run_row(tbl_a[i], $sformatf("A%0d", i));
    end

    // L=12 straddling word, finish raised while the word waits, then flush of the remainder.
    do_reset();
    run_row(mk(0,1,1,0,0,16'h0000,0,4'd12, 0,0,32'h0,0,0,0), "B0");
    run_row(mk(0,0,1,0,1,16'h0ABC,0,4'd12, 1,0,32'h0,0,1,0), "B1");
    run_row(mk(0,0,1,0,1,16'h0123,0,4'd12, 1,0,32'h0,0,1,0), "B2");
    run_row(mk(0,0,1,0,1,16'h0456,0,4'd12, 1,0,32'h0,0,1,0), "B3");
    run_row(mk(0,0,1,1,0,16'h0000,0,4'd12, 0,1,32'h56123ABC,0,1,0), "B4");
    run_row(mk(0,0,1,0,0,16'h0000,1,4'd12, 0,1,32'h56123ABC,0,1,0), "B5");
    run_row(mk(0,0,1,0,0,16'h0000,0,4'd12, 1,0,32'h0,1,1,0), "B6");
    run_row(mk(0,0,1,0,0,16'h0000,1,4'd12, 0,1,32'h00000004,1,1,0), "B7");
    run_row(mk(0,0,1,0,0,16'h0000,0,4'd12, 0,0,32'h0,2,1,1), "B8");
    run_row(mk(0,0,1,0,0,16'h0000,0,4'd12, 0,0,32'h0,2,0,0), "B9");

    // Start keeps word_counter; reset while a word is pending returns everything to zero.
    run_row(mk(0,1,1,0,0,16'h0000,0,4'd8, 0,0,32'h0,2,0,0), "C0");
    run_row(mk(0,0,1,0,1,16'h0001,0,4'd8, 1,0,32'h0,2,1,0), "C1");
    run_row(mk(0,0,1,0,1,16'h0002,0,4'd8, 1,0,32'h0,2,1,0), "C2");
    run_row(mk(0,0,1,0,1,16'h0003,0,4'd8, 1,0,32'h0,2,1,0), "C3");
    run_row(mk(0,0,1,0,1,16'h0004,0,4'd8, 1,0,32'h0,2,1,0), "C4");
    run_row(mk(1,0,1,0,0,16'h0000,0,4'd8, 0,1,32'h04030201,2,1,0), "C5");
    run_row(mk(1,0,1,0,0,16'h0000,0,4'd8, 0,0,32'h0,0,0,0), "C6");
    run_row(mk(0,0,1,0,0,16'h0000,0,4'd8, 0,0,32'h0,0,0,0), "C7");

    // L=0 discards counts, so finish finds nothing to flush.
    run_row(mk(0,1,1,0,0,16'h0000,0,4'd0, 0,0,32'h0,0,0,0), "D0");
    run_row(mk(0,0,1,0,1,16'hFFFF,0,4'd0, 1,0,32'h0,0,1,0), "D1");
    run_row(mk(0,0,1,1,0,16'h0000,0,4'd0, 1,0,32'h0,0,1,0), "D2");
    run_row(mk(0,0,1,0,0,16'h0000,0,4'd0, 0,0,32'h0,0,1,1), "D3");
    run_row(mk(0,0,1,0,0,16'h0000,0,4'd0, 0,0,32'h0,0,0,0), "D4");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
